wb_sequencer: RTL and testbench
===============================

WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 Parameter DEPTH, default 2, request FIFO depth in entries; legal values 1..4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid / in_ready  input / output  1 each  execute-to-writeback handshake; transfer when both are high at a clk edge.
REQ-005 in_ws1, in_ws2  input  4 each  primary and secondary destination registers (15 = pc).
REQ-006 in_wd1, in_wd2  input  32 each  primary and secondary write data.
REQ-007 in_we1, in_we2  input  1 each  primary and secondary write enables.
REQ-008 in_next_cpsr  input  32; in_set_cond  input  1  new flags and flag-update request.
REQ-009 rf_ws1, rf_ws2  output  4; rf_wd1, rf_wd2  output  32; rf_we1, rf_we2  output  1  register-file write-port drive.
REQ-010 do_write1, do_write2  output  1 each  write-phase strobes to the register file.
REQ-011 next_cpsr  output  32; set_cond_bits  output  1  flag commit to the register file.
REQ-012 busy  output  16  per-register pending-write mask for hazard stall logic.
REQ-013 pc_wr  output  1  one-cycle pulse when a write to register 15 is issued.

Function
REQ-014 in_ready SHALL be 1 whenever the FIFO holds fewer than DEPTH entries; there is no same-cycle pass-through when full.
REQ-015 A request with in_we1=in_we2=in_set_cond=0 SHALL be accepted and discarded, not stored.
REQ-016 The FSM SHALL use states IDLE, W1 and W2 and operate on the FIFO head entry.
REQ-017 IDLE->W1 when the head needs phase 1 (we1 or set_cond); IDLE->W2 when only we2 is set.
REQ-018 W1->W2 when head we2=1; otherwise W1 pops the head and goes to IDLE.
REQ-019 W2 pops the head and goes to IDLE.
REQ-020 In W1: do_write1=1, rf_we1=head we1, set_cond_bits=head set_cond, do_write2=0.
REQ-021 In W2: do_write2=1, rf_we2=1, do_write1=0, set_cond_bits=0.
REQ-022 The do_write1 and do_write2 strobes SHALL never be high in the same cycle.
REQ-023 The rf_ws*/rf_wd*/next_cpsr outputs SHALL always reflect the head entry, or zero when the FIFO is empty.
REQ-024 Latency: a request accepted at edge N into an empty FIFO SHALL drive W1 (or W2) during the cycle after edge N; one phase per cycle.
REQ-025 busy SHALL be the OR over valid entries of one-hot(ws1) when we1 and phase 1 is unissued, and one-hot(ws2) when we2 and phase 2 is unissued.
REQ-026 A busy bit SHALL clear at the edge its phase issues; busy SHALL update at the accept edge.
REQ-027 ws1=ws2 with both enabled: both phases SHALL issue in order; ws2 data is final.
REQ-028 pc_wr SHALL pulse in the cycle a phase writes register 15.
REQ-029 A simultaneous push and pop in the same cycle SHALL both take effect, with FIFO order preserved.

Reset
REQ-030 While rst is high: FIFO empty, FSM in IDLE, and every output 0 except in_ready=1.
REQ-031 Reset mid-operation SHALL discard pending entries and unissued phases; no strobe SHALL fire in the cycle after rst deasserts.

Configuration
REQ-032 With WB_FWD_EN defined: add input fwd_rs (4) and outputs fwd_hit (1) and fwd_data (32), giving the youngest pending unissued write to fwd_rs, combinationally.
REQ-033 Without WB_FWD_EN: these ports are absent and busy is the only hazard information.

Structure
REQ-034 The shared arm32 package SHALL hold the FSM state encoding, the PC_REG=15 constant and the wb_req_t entry typedef.
REQ-035 The FIFO SHALL be the sub-module wb_req_fifo (DEPTH entries, wb_req_t payload); the FSM, busy and forwarding logic SHALL live in wb_sequencer.

Verification
REQ-036 Push ws1=3, wd1=0x11, we1=1 -> next cycle do_write1=1, rf_ws1=3; busy[3] is 1 then 0.
REQ-037 Push we1=1 ws1=4, we2=1 ws2=5 -> W1 (r4), then W2 (r5) in consecutive cycles, never overlapping.
REQ-038 Push in_set_cond=1, we1=0, next_cpsr=0xF0000000 -> do_write1=1, rf_we1=0, set_cond_bits=1, next_cpsr=0xF0000000.
REQ-039 With DEPTH=2, three back-to-back pushes of two-phase requests -> in_ready drops on the third; all six phases issue in order.
REQ-040 Assert rst during W1 of a two-phase request -> no W2; busy=0 and in_ready=1.
REQ-041 Under WB_FWD_EN, two pending writes to r7 (0xA then 0xB) with fwd_rs=7 -> fwd_hit=1, fwd_data=0xB.

Source files
------------

// File: rtl/wb_sequencer_pkg.sv
// wb_sequencer_pkg: shared arm32 writeback types, FSM encoding and PC constant
package wb_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, W1, W2} wb_state_t;
  localparam logic [3:0] PC_REG = 4'd15;
  typedef struct packed {
    logic [3:0]  ws1;
    logic [3:0]  ws2;
    logic [31:0] wd1;
    logic [31:0] wd2;
    logic        we1;
    logic        we2;
    logic [31:0] cpsr;
    logic        sc;
  } wb_req_t;
  function automatic wb_state_t first_phase(wb_req_t e);
    return (e.we1 || e.sc) ? W1 : W2;
  endfunction
endpackage

// File: rtl/wb_sequencer_if.sv
// wb_sequencer_if: execute-to-writeback request handshake
interface wb_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_ws1;
  logic [3:0]  in_ws2;
  logic [31:0] in_wd1;
  logic [31:0] in_wd2;
  logic        in_we1;
  logic        in_we2;
  logic [31:0] in_next_cpsr;
  logic        in_set_cond;
  modport master (output in_valid, in_ws1, in_ws2, in_wd1, in_wd2, in_we1, in_we2, in_next_cpsr, in_set_cond, input in_ready);
  modport slave (input in_valid, in_ws1, in_ws2, in_wd1, in_wd2, in_we1, in_we2, in_next_cpsr, in_set_cond, output in_ready);
endinterface

// File: rtl/wb_req_fifo.sv
// wb_req_fifo: shift-register request FIFO, entry 0 is the head; vacated slots read as zero
module wb_req_fifo
  import wb_sequencer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  wb_req_t    din,
  output wb_req_t    q [DEPTH],
  output logic [2:0] cnt,
  output wb_req_t    nhead,
  output logic [2:0] ncnt
);
  wb_req_t nxt [DEPTH];
  always_comb begin
    nxt = q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) nxt[i] = q[i + 1];
      nxt[DEPTH - 1] = '0;
    end
    for (int i = 0; i < DEPTH; i++) if (push && i == int'(cnt) - int'(pop)) nxt[i] = din;
    ncnt = cnt + 3'(push) - 3'(pop);
  end
  assign nhead = nxt[0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '{default: '0};
      cnt <= '0;
    end else begin
      q   <= nxt;
      cnt <= ncnt;
    end
  end
endmodule

// File: rtl/wb_sequencer.sv
// wb_sequencer: two-phase register-file writeback sequencer with pending-write busy mask
// Optional WB_FWD_EN adds a combinational forwarding port for the youngest pending write.
module wb_sequencer
  import wb_sequencer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  wb_sequencer_if.slave     bus,
  output logic [3:0]        rf_ws1,
  output logic [3:0]        rf_ws2,
  output logic [31:0]       rf_wd1,
  output logic [31:0]       rf_wd2,
  output logic              rf_we1,
  output logic              rf_we2,
  output logic              do_write1,
  output logic              do_write2,
  output logic [31:0]       next_cpsr,
  output logic              set_cond_bits,
  output logic [15:0]       busy,
  output logic              pc_wr
`ifdef WB_FWD_EN
  ,
  input  logic [3:0]        fwd_rs,
  output logic              fwd_hit,
  output logic [31:0]       fwd_data
`endif
);
  wb_state_t  state, state_n;
  wb_req_t    q [DEPTH];
  wb_req_t    head, nhead, din;
  logic [2:0] cnt, ncnt;
  logic       push, pop;
  assign din = '{ws1: bus.in_ws1, ws2: bus.in_ws2, wd1: bus.in_wd1, wd2: bus.in_wd2,
                 we1: bus.in_we1, we2: bus.in_we2, cpsr: bus.in_next_cpsr, sc: bus.in_set_cond};
  assign bus.in_ready = cnt < 3'(DEPTH);
  assign push = bus.in_valid && bus.in_ready && (din.we1 || din.we2 || din.sc);
  assign head = q[0];
  wb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .q(q), .cnt(cnt), .nhead(nhead), .ncnt(ncnt)
  );
  // State is chosen from the head as it will be after this edge, so a fresh entry issues next cycle.
  always_comb begin
    pop     = (state == W1 && !head.we2) || state == W2;
    state_n = (state == W1 && head.we2) ? W2 : (ncnt != 3'd0 ? first_phase(nhead) : IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  assign do_write1     = state == W1;
  assign do_write2     = state == W2;
  assign rf_we1        = do_write1 && head.we1;
  assign rf_we2        = do_write2;
  assign set_cond_bits = do_write1 && head.sc;
  assign rf_ws1        = head.ws1;
  assign rf_ws2        = head.ws2;
  assign rf_wd1        = head.wd1;
  assign rf_wd2        = head.wd2;
  assign next_cpsr     = head.cpsr;
  assign pc_wr         = (rf_we1 && head.ws1 == PC_REG) || (rf_we2 && head.ws2 == PC_REG);
  // Phase 1 of the head has issued exactly when the FSM sits in W2.
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].we1 && !(i == 0 && state == W2)) busy = busy | (16'd1 << q[i].ws1);
      if (q[i].we2) busy = busy | (16'd1 << q[i].ws2);
    end
  end
`ifdef WB_FWD_EN
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].we1 && q[i].ws1 == fwd_rs && !(i == 0 && state == W2)) begin
        fwd_hit  = 1'b1;
        fwd_data = q[i].wd1;
      end
      if (q[i].we2 && q[i].ws2 == fwd_rs) begin
        fwd_hit  = 1'b1;
        fwd_data = q[i].wd2;
      end
    end
  end
`endif
endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: directed self-checking bench for wb_sequencer (DEPTH=2)
module tb_wb_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rf_ws1, rf_ws2;
  logic [31:0] rf_wd1, rf_wd2, next_cpsr;
  logic        rf_we1, rf_we2, do_write1, do_write2, set_cond_bits, pc_wr;
  logic [15:0] busy;
  int          tests = 0;
  int          errs = 0;
`ifdef WB_FWD_EN
  logic [3:0]  fwd_rs = 4'd0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif
  always #5 clk = ~clk;
  wb_sequencer_if bus();
  wb_sequencer #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rf_ws1(rf_ws1), .rf_ws2(rf_ws2), .rf_wd1(rf_wd1), .rf_wd2(rf_wd2),
    .rf_we1(rf_we1), .rf_we2(rf_we2), .do_write1(do_write1), .do_write2(do_write2),
    .next_cpsr(next_cpsr), .set_cond_bits(set_cond_bits), .busy(busy), .pc_wr(pc_wr)
`ifdef WB_FWD_EN
    , .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input logic [3:0] ws1, input logic [31:0] wd1, input logic we1,
                         input logic [3:0] ws2, input logic [31:0] wd2, input logic we2,
                         input logic [31:0] cpsr, input logic sc);
    bus.in_ws1 = ws1;
    bus.in_wd1 = wd1;
    bus.in_we1 = we1;
    bus.in_ws2 = ws2;
    bus.in_wd2 = wd2;
    bus.in_we2 = we2;
    bus.in_next_cpsr = cpsr;
    bus.in_set_cond = sc;
    bus.in_valid = 1'b1;
  endtask
  task automatic push(input logic [3:0] ws1, input logic [31:0] wd1, input logic we1,
                      input logic [3:0] ws2, input logic [31:0] wd2, input logic we2,
                      input logic [31:0] cpsr, input logic sc);
    set_req(ws1, wd1, we1, ws2, wd2, we2, cpsr, sc);
    tick();
    bus.in_valid = 1'b0;
  endtask
  always @(negedge clk) if (!rst) chk("no_overlap", 32'(do_write1 && do_write2), 32'd0);
  initial begin
    set_req(4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_dw1", 32'(do_write1), 32'd0);
    chk("rst_dw2", 32'(do_write2), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ws1", 32'(rf_ws1), 32'd0);
    chk("rst_pcwr", 32'(pc_wr), 32'd0);
    rst = 1'b0;
    tick();
    push(4'd3, 32'h11, 1'b1, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    chk("single_dw1", 32'(do_write1), 32'd1);
    chk("single_ws1", 32'(rf_ws1), 32'd3);
    chk("single_wd1", rf_wd1, 32'h11);
    chk("single_we1", 32'(rf_we1), 32'd1);
    chk("single_busy_set", 32'(busy), 32'h0008);
    tick();
    chk("single_done", 32'(do_write1), 32'd0);
    chk("single_busy_clr", 32'(busy), 32'd0);
    push(4'd4, 32'h44, 1'b1, 4'd5, 32'h55, 1'b1, 32'd0, 1'b0);
    chk("two_w1", 32'(do_write1), 32'd1);
    chk("two_w1_ws1", 32'(rf_ws1), 32'd4);
    chk("two_w1_busy", 32'(busy), 32'h0030);
    tick();
    chk("two_w2", 32'(do_write2), 32'd1);
    chk("two_w2_dw1", 32'(do_write1), 32'd0);
    chk("two_w2_ws2", 32'(rf_ws2), 32'd5);
    chk("two_w2_wd2", rf_wd2, 32'h55);
    chk("two_w2_we2", 32'(rf_we2), 32'd1);
    chk("two_w2_busy", 32'(busy), 32'h0020);
    tick();
    chk("two_done", 32'(do_write2), 32'd0);
    chk("two_busy_clr", 32'(busy), 32'd0);
    push(4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'hF000_0000, 1'b1);
    chk("cond_dw1", 32'(do_write1), 32'd1);
    chk("cond_we1", 32'(rf_we1), 32'd0);
    chk("cond_set", 32'(set_cond_bits), 32'd1);
    chk("cond_cpsr", next_cpsr, 32'hF000_0000);
    chk("cond_busy", 32'(busy), 32'd0);
    tick();
    chk("cond_clr", 32'(set_cond_bits), 32'd0);
    chk("cond_cpsr_clr", next_cpsr, 32'd0);
    push(4'd9, 32'h99, 1'b0, 4'd9, 32'h99, 1'b0, 32'd0, 1'b0);
    chk("discard_dw1", 32'(do_write1), 32'd0);
    chk("discard_dw2", 32'(do_write2), 32'd0);
    chk("discard_ws1", 32'(rf_ws1), 32'd0);
    push(4'd15, 32'h100, 1'b1, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    chk("pc1_pulse", 32'(pc_wr), 32'd1);
    tick();
    chk("pc1_end", 32'(pc_wr), 32'd0);
    push(4'd0, 32'd0, 1'b0, 4'd15, 32'h200, 1'b1, 32'd0, 1'b0);
    chk("only2_dw2", 32'(do_write2), 32'd1);
    chk("only2_dw1", 32'(do_write1), 32'd0);
    chk("only2_pc", 32'(pc_wr), 32'd1);
    tick();
    chk("only2_end", 32'(do_write2), 32'd0);
    push(4'd6, 32'hA, 1'b1, 4'd6, 32'hB, 1'b1, 32'd0, 1'b0);
    chk("same_w1_wd", rf_wd1, 32'hA);
    chk("same_w1_busy", 32'(busy), 32'h0040);
    tick();
    chk("same_w2_wd", rf_wd2, 32'hB);
    chk("same_w2_busy", 32'(busy), 32'h0040);
    tick();
    chk("same_busy_clr", 32'(busy), 32'd0);
    set_req(4'd1, 32'h1, 1'b1, 4'd2, 32'h2, 1'b1, 32'd0, 1'b0);
    tick();
    chk("b2b_a_ready", 32'(bus.in_ready), 32'd1);
    chk("b2b_a_w1", 32'(rf_ws1 & {4{do_write1}}), 32'd1);
    set_req(4'd3, 32'h3, 1'b1, 4'd4, 32'h4, 1'b1, 32'd0, 1'b0);
    tick();
    chk("b2b_full", 32'(bus.in_ready), 32'd0);
    chk("b2b_a_w2", 32'(rf_ws2 & {4{do_write2}}), 32'd2);
    chk("b2b_busy", 32'(busy), 32'h001C);
    set_req(4'd6, 32'h6, 1'b1, 4'd8, 32'h8, 1'b1, 32'd0, 1'b0);
    tick();
    chk("b2b_b_w1", 32'(rf_ws1 & {4{do_write1}}), 32'd3);
    chk("b2b_ready_back", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_b_w2", 32'(rf_ws2 & {4{do_write2}}), 32'd4);
    tick();
    chk("b2b_c_w1", 32'(rf_ws1 & {4{do_write1}}), 32'd6);
    tick();
    chk("b2b_c_w2", 32'(rf_ws2 & {4{do_write2}}), 32'd8);
    chk("b2b_c_wd2", rf_wd2, 32'h8);
    tick();
    chk("b2b_idle", 32'({do_write1, do_write2}), 32'd0);
    chk("b2b_busy_clr", 32'(busy), 32'd0);
    push(4'd4, 32'h44, 1'b1, 4'd5, 32'h55, 1'b1, 32'd0, 1'b0);
    chk("rstmid_w1", 32'(do_write1), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ready", 32'(bus.in_ready), 32'd1);
    chk("rstmid_dw1", 32'(do_write1), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstmid_no_w2", 32'(do_write2), 32'd0);
    chk("rstmid_no_w1", 32'(do_write1), 32'd0);
`ifdef WB_FWD_EN
    fwd_rs = 4'd7;
    push(4'd1, 32'h1, 1'b1, 4'd7, 32'hA, 1'b1, 32'd0, 1'b0);
    chk("fwd_hit_a", 32'(fwd_hit), 32'd1);
    chk("fwd_data_a", fwd_data, 32'hA);
    push(4'd7, 32'hB, 1'b1, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    chk("fwd_hit_b", 32'(fwd_hit), 32'd1);
    chk("fwd_data_b", fwd_data, 32'hB);
    tick();
    tick();
    chk("fwd_drained", 32'(fwd_hit), 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
